dmaster_b2p_channel_filter: RTL and testbench

Receive-side channel adapter for the debug-master byte/packet path: accepts a channelized Avalon-ST packet stream, keeps only packets whose channel matches the configured channel, and forwards them channel-stripped to the packet consumer. It sits between the bytes-to-packets converter and the packet-to-transaction master, inverse to the transmit-side adapter that inserts the channel field. Output is registered through a skid buffer, so the block provides full throughput with one cycle of latency.

---
 rtl/dmaster_pkg.sv | 21 ++
 rtl/dmaster_st_skid_buffer.sv | 84 ++++++++
 rtl/dmaster_b2p_channel_filter.sv | 141 ++++++++++++++
 tb/tb_dmaster_b2p_channel_filter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmaster_pkg.sv
// ---------------------------------------------------------------------------
// dmaster_pkg
//   Shared definitions for the debug-master byte/packet path.
//   - b2p_state_e : receive-side channel classifier states
//   - DEFAULT_*   : default widths used by the channel adapters
// ---------------------------------------------------------------------------
package dmaster_pkg;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_CHANNEL_W = 8;
    localparam int DEFAULT_CNT_W     = 16;

    // IDLE: between packets, PASS: inside an accepted packet,
    // DROP: inside a rejected packet.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } b2p_state_e;

endpackage

// File: rtl/dmaster_st_skid_buffer.sv
// ---------------------------------------------------------------------------
// dmaster_st_skid_buffer
//   Two-entry registered Avalon-ST slice carrying {data, sop, eop}.
//   Entry 1 is the output register, entry 2 is the skid slot that catches a
//   beat accepted while the output is stalled. in_ready is a pure register
//   output ("skid slot empty"), so no combinational path exists from
//   out_ready to in_ready.
//
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     in_valid/in_ready          upstream handshake
//     in_data/in_sop/in_eop      upstream payload
//     out_valid/out_ready        downstream handshake
//     out_data/out_sop/out_eop   registered downstream payload
// ---------------------------------------------------------------------------
module dmaster_st_skid_buffer
    import dmaster_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop
);

    localparam int PAYLOAD_W = DATA_W + 2;

    logic                 out_valid_reg;
    logic                 skid_valid_reg;
    logic [PAYLOAD_W-1:0] out_payload_reg;
    logic [PAYLOAD_W-1:0] skid_payload_reg;

    logic [PAYLOAD_W-1:0] in_payload;
    logic                 accept;
    logic                 load_out;

    assign in_payload = {in_data, in_sop, in_eop};
    assign accept     = in_valid && !skid_valid_reg;
    // The output register may take a new beat when empty or being consumed.
    assign load_out   = !out_valid_reg || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg    <= 1'b0;
            skid_valid_reg   <= 1'b0;
            out_payload_reg  <= '0;
            skid_payload_reg <= '0;
        end else begin
            if (load_out) begin
                // The skid slot is older than any incoming beat, so it drains
                // first. While it is full in_ready is low and accept is 0.
                if (skid_valid_reg) begin
                    out_payload_reg <= skid_payload_reg;
                    out_valid_reg   <= 1'b1;
                    skid_valid_reg  <= 1'b0;
                end else if (accept) begin
                    out_payload_reg <= in_payload;
                    out_valid_reg   <= 1'b1;
                end else begin
                    out_valid_reg   <= 1'b0;
                end
            end else if (accept) begin
                skid_payload_reg <= in_payload;
                skid_valid_reg   <= 1'b1;
            end
        end
    end

    assign in_ready  = !skid_valid_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_payload_reg[PAYLOAD_W-1:2];
    assign out_sop   = out_payload_reg[1];
    assign out_eop   = out_payload_reg[0];

endmodule

// File: rtl/dmaster_b2p_channel_filter.sv
// ---------------------------------------------------------------------------
// dmaster_b2p_channel_filter
//   Receive-side channel adapter: forwards only packets whose SOP channel
//   equals ACCEPT_CHANNEL, with the channel field stripped. Output goes
//   through a 2-entry skid buffer (one cycle latency, full throughput).
//
//   Optional feature macro: DMASTER_B2P_DROP_COUNT_EN
//     When defined, adds the drop_count port: a saturating count of rejected
//     packets (mismatching SOP beats) plus orphan beats seen while idle.
//
//   Ports:
//     clk, reset                       clock, asynchronous active-high reset
//     in_valid/in_ready                input handshake (in_ready = skid empty)
//     in_data, in_channel              payload, channel (used on SOP only)
//     in_startofpacket/endofpacket     packet framing
//     out_valid/out_ready              output handshake
//     out_data, out_startofpacket/eop  forwarded beat
//     drop_count                       dropped count (macro builds only)
// ---------------------------------------------------------------------------
module dmaster_b2p_channel_filter
    import dmaster_pkg::*;
#(
    parameter int                   DATA_W         = DEFAULT_DATA_W,
    parameter int                   CHANNEL_W      = DEFAULT_CHANNEL_W,
    parameter logic [CHANNEL_W-1:0] ACCEPT_CHANNEL = '0,
    parameter int                   CNT_W          = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [CHANNEL_W-1:0] in_channel,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket
`ifdef DMASTER_B2P_DROP_COUNT_EN
    ,
    output logic [CNT_W-1:0]     drop_count
`endif
);

    b2p_state_e state_reg;
    b2p_state_e state_next;

    logic beat_accepted;
    logic ch_match;
    logic fwd;

    // in_ready gates every beat, including ones that will be discarded, so
    // the upstream sees one uniform handshake regardless of channel.
    assign beat_accepted = in_valid && in_ready;
    assign ch_match      = (in_channel == ACCEPT_CHANNEL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fwd        = 1'b0;
        if (beat_accepted) begin
            if (in_startofpacket) begin
                // An SOP always reclassifies, even mid-packet. A packet cut
                // short this way is left unterminated downstream.
                if (ch_match) begin
                    fwd        = 1'b1;
                    state_next = ST_PASS;
                end else begin
                    state_next = ST_DROP;
                end
                if (in_endofpacket) begin
                    state_next = ST_IDLE;
                end
            end else begin
                case (state_reg)
                    ST_PASS: begin
                        fwd = 1'b1;
                        if (in_endofpacket) begin
                            state_next = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (in_endofpacket) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        // Orphan beat between packets: discarded.
                        state_next = ST_IDLE;
                    end
                endcase
            end
        end
    end

    dmaster_st_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fwd),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sop    (in_startofpacket),
        .in_eop    (in_endofpacket),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_startofpacket),
        .out_eop   (out_endofpacket)
    );

`ifdef DMASTER_B2P_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_count_reg;
    logic             drop_inc;

    assign drop_inc = beat_accepted &&
                      ((in_startofpacket && !ch_match) ||
                       (!in_startofpacket && (state_reg == ST_IDLE)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_reg <= '0;
        end else if (drop_inc && (drop_count_reg != {CNT_W{1'b1}})) begin
            drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

    assign drop_count = drop_count_reg;
`endif

endmodule

// File: tb/tb_dmaster_b2p_channel_filter.sv
// ---------------------------------------------------------------------------
// tb_dmaster_b2p_channel_filter
//   Scoreboard bench: forwarded beats are queued when driven and popped when
//   they leave the DUT. An occupancy model predicts in_ready/out_valid, and
//   stalled outputs are checked for stability. Drop-count checks are compiled
//   in when DMASTER_B2P_DROP_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dmaster_b2p_channel_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  in_channel;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_startofpacket;
    logic        out_endofpacket;
`ifdef DMASTER_B2P_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    dmaster_b2p_channel_filter dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_channel        (in_channel),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
`ifdef DMASTER_B2P_DROP_COUNT_EN
        ,
        .drop_count        (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          fails     = 0;
    logic [9:0]  sb[$];
    int          occ = 0;
    bit          cur_fwd = 0;
    bit          ready_must_be_high = 0;
    int          rdy_mode = 0;       // 0: always ready, 1: pattern, 2: stalled
    logic [3:0]  rdy_pat = 4'b1001;
    logic [15:0] exp_drops = '0;

    // Downstream ready generator.
    task automatic run_ready_driver();
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = rdy_pat[ph];
                    ph = (ph + 1) % 4;
                end
                default: out_ready = 1'b0;
            endcase
        end
    endtask

    // Output monitor: scoreboard pop, stall stability, occupancy model.
    task automatic run_monitor();
        bit         prev_stall = 0;
        logic [9:0] held = '0;
        logic [9:0] got;
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                occ        = 0;
                prev_stall = 0;
            end else begin
                got = {out_data, out_startofpacket, out_endofpacket};
                tests_run++;
                if (in_ready !== (occ < 2)) begin
                    fails++;
                    $display("FAIL in_ready_model t=%0t got=%b want=%b", $time, in_ready, (occ < 2));
                end
                tests_run++;
                if (out_valid !== (occ > 0)) begin
                    fails++;
                    $display("FAIL out_valid_model t=%0t got=%b want=%b", $time, out_valid, (occ > 0));
                end
                if (ready_must_be_high) begin
                    tests_run++;
                    if (in_ready !== 1'b1) begin
                        fails++;
                        $display("FAIL in_ready_high t=%0t got=%b want=1", $time, in_ready);
                    end
                end
                if (prev_stall) begin
                    tests_run++;
                    if (got !== held || out_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL stall_stable t=%0t got=%h want=%h", $time, got, held);
                    end
                end
                if (out_valid && out_ready) begin
                    tests_run++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat t=%0t got=%h want=none", $time, got);
                    end else begin
                        exp = sb.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("FAIL beat t=%0t got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                                     $time, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
                        end else begin
                            $display("[TB] out beat data=%h sop=%b eop=%b", got[9:2], got[1], got[0]);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                held       = got;
                occ = occ + ((in_valid && in_ready && cur_fwd) ? 1 : 0)
                          - ((out_valid && out_ready) ? 1 : 0);
            end
        end
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [7:0] d, input logic [7:0] ch,
                             input logic sop, input logic eop, input bit fwd);
        int waited = 0;
        in_data          = d;
        in_channel       = ch;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_valid         = 1'b1;
        cur_fwd          = fwd;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (fwd) sb.push_back({d, sop, eop});
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 100) begin
                tests_run++;
                fails++;
                $display("FAIL accept_timeout data=%h got=no_accept want=accept", d);
                break;
            end
        end
        in_valid = 1'b0;
        cur_fwd  = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain got=%0d pending want=0", name, sb.size());
        end
    endtask

    task automatic check_drops(input string name);
`ifdef DMASTER_B2P_DROP_COUNT_EN
        tests_run++;
        if (drop_count !== exp_drops) begin
            fails++;
            $display("FAIL %s_drop_count got=%0d want=%0d", name, drop_count, exp_drops);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=0",
                     {out_valid, out_data, out_startofpacket, out_endofpacket});
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        check_drops("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pass();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        ready_must_be_high = 1;
        send_beat(8'h11, 8'd0, 1'b1, 1'b0, 1'b1);
        send_beat(8'h12, 8'd0, 1'b0, 1'b0, 1'b1);
        send_beat(8'h13, 8'd0, 1'b0, 1'b0, 1'b1);
        send_beat(8'h14, 8'd0, 1'b0, 1'b1, 1'b1);
        drain("pass");
        ready_must_be_high = 0;
        check_drops("pass");
    endtask

    task automatic test_mismatch();
        send_beat(8'h01, 8'd3, 1'b1, 1'b0, 1'b0);
        send_beat(8'h02, 8'd3, 1'b0, 1'b0, 1'b0);
        send_beat(8'h03, 8'd3, 1'b0, 1'b1, 1'b0);
        exp_drops++;
        send_beat(8'hA5, 8'd0, 1'b1, 1'b1, 1'b1);
        drain("mismatch");
        check_drops("mismatch");
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h21 + 8'(i), 8'd0, (i == 0), (i == 7), 1'b1);
        end
        drain("backpressure");
        rdy_mode = 0;
        check_drops("backpressure");
    endtask

    task automatic test_orphan();
        send_beat(8'h55, 8'd0, 1'b0, 1'b0, 1'b0);
        exp_drops++;
        send_beat(8'h56, 8'd0, 1'b1, 1'b0, 1'b1);
        send_beat(8'h57, 8'd0, 1'b0, 1'b1, 1'b1);
        drain("orphan");
        check_drops("orphan");
    endtask

    task automatic test_reclassify();
        send_beat(8'h31, 8'd0, 1'b1, 1'b0, 1'b1);
        send_beat(8'h32, 8'd0, 1'b0, 1'b0, 1'b1);
        send_beat(8'h40, 8'd2, 1'b1, 1'b0, 1'b0);
        exp_drops++;
        send_beat(8'h41, 8'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'h42, 8'd0, 1'b0, 1'b1, 1'b0);
        send_beat(8'h50, 8'd0, 1'b1, 1'b1, 1'b1);
        drain("reclassify");
        check_drops("reclassify");
    endtask

    task automatic test_reset_mid_packet();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_beat(8'h61, 8'd0, 1'b1, 1'b0, 1'b1);
        send_beat(8'h62, 8'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        tests_run++;
        if ({out_data, out_startofpacket, out_endofpacket} !== 10'd0) begin
            fails++;
            $display("FAIL async_reset_data got=%h want=0", {out_data, out_startofpacket, out_endofpacket});
        end
        sb.delete();
        exp_drops = '0;
        check_drops("async_reset");
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_beat(8'h71, 8'd0, 1'b1, 1'b0, 1'b1);
        send_beat(8'h72, 8'd0, 1'b0, 1'b1, 1'b1);
        drain("post_reset");
        check_drops("post_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_data          = '0;
        in_channel       = '0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        out_ready        = 1'b1;
        fork
            run_ready_driver();
            run_monitor();
        join_none
        test_reset();
        test_pass();
        test_mismatch();
        test_backpressure();
        test_orphan();
        test_reclassify();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
